// File: rtl/spirit_line_scheduler_if.sv
// Bundle between the line scheduler, the video timing generator, the sprite
// memory read port and the line renderer.
//   i_line_start/i_line_y : line evaluation request from timing
//   o_spirit_idx          : read index to sprite memory (1-cycle latency)
//   i_spirit_struct       : 64-bit sprite struct for last cycle's index
//   o_busy/o_done/o_overflow : scan status
//   o_slot_*              : flattened slot outputs, slot n at [n*W +: W]
interface spirit_line_scheduler_if #(
  parameter int IDX_W        = 5,
  parameter int MAX_PER_LINE = 8
);
  logic                          i_line_start;
  logic [15:0]                   i_line_y;
  logic [IDX_W-1:0]              o_spirit_idx;
  logic [63:0]                   i_spirit_struct;
  logic                          o_busy;
  logic                          o_done;
  logic                          o_overflow;
  logic [MAX_PER_LINE-1:0]       o_slot_valid;
  logic [MAX_PER_LINE*IDX_W-1:0] o_slot_idx;
  logic [MAX_PER_LINE*16-1:0]    o_slot_x;
  logic [MAX_PER_LINE*8-1:0]     o_slot_row;

  // environment side: timing generator + sprite memory + renderer
  modport master (
    output i_line_start, i_line_y, i_spirit_struct,
    input  o_spirit_idx, o_busy, o_done, o_overflow,
           o_slot_valid, o_slot_idx, o_slot_x, o_slot_row
  );

  // scheduler side
  modport slave (
    input  i_line_start, i_line_y, i_spirit_struct,
    output o_spirit_idx, o_busy, o_done, o_overflow,
           o_slot_valid, o_slot_idx, o_slot_x, o_slot_row
  );
endinterface

// File: rtl/spirit_line_scheduler.sv
// Per-scanline sprite evaluator. On a line-start pulse it walks every sprite
// index (one per cycle), evaluates the returned struct one cycle later and
// packs up to MAX_PER_LINE covering sprites into output slots.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : spirit_line_scheduler_if.slave (request, memory read, slots)
module spirit_line_scheduler #(
  parameter int SPIRIT_COUNT = 32,
  parameter int IDX_W        = 5,
  parameter int MAX_PER_LINE = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  spirit_line_scheduler_if.slave  bus
);
  localparam int FILL_W = $clog2(MAX_PER_LINE + 1);
  localparam logic [IDX_W-1:0]  IDX_MAX  = IDX_W'(SPIRIT_COUNT - 1);
  localparam logic [IDX_W:0]    CNT_LAST = (IDX_W + 1)'(SPIRIT_COUNT);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(MAX_PER_LINE);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t                                state;
  logic [15:0]                           line_y;
  logic [IDX_W-1:0]                      idx;
  // cnt = cycles since scan start; struct for index cnt-1 is on the bus
  // whenever cnt != 0, the last one when cnt == SPIRIT_COUNT.
  logic [IDX_W:0]                        cnt;
  logic [FILL_W-1:0]                     fill;
  logic                                  done;
  logic                                  overflow;
  logic [MAX_PER_LINE-1:0]               slot_valid;
  logic [MAX_PER_LINE-1:0][IDX_W-1:0]    slot_idx;
  logic [MAX_PER_LINE-1:0][15:0]         slot_x;
  logic [MAX_PER_LINE-1:0][7:0]          slot_row;

  // struct decode and hit test (unsigned 17-bit, no wrap)
  logic [15:0]    s_x, s_y;
  logic [7:0]     s_h;
  logic           s_en;
  logic [16:0]    diff;
  logic           hit;
  logic [IDX_W:0] cnt_m1;
  logic [IDX_W-1:0] eval_idx;

  assign s_x      = bus.i_spirit_struct[15:0];
  assign s_y      = bus.i_spirit_struct[31:16];
  assign s_h      = bus.i_spirit_struct[39:32];
  assign s_en     = bus.i_spirit_struct[40];
  assign diff     = {1'b0, line_y} - {1'b0, s_y};
  assign hit      = s_en && (line_y >= s_y) && (diff < {9'd0, s_h});
  assign cnt_m1   = cnt - 1'b1;
  assign eval_idx = cnt_m1[IDX_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      line_y     <= '0;
      idx        <= '0;
      cnt        <= '0;
      fill       <= '0;
      done       <= 1'b0;
      overflow   <= 1'b0;
      slot_valid <= '0;
      slot_idx   <= '0;
      slot_x     <= '0;
      slot_row   <= '0;
    end else begin
      done <= 1'b0;
      // a new request always wins, including over the final evaluation,
      // so an aborted line never reports done
      if (bus.i_line_start) begin
        state      <= SCAN;
        line_y     <= bus.i_line_y;
        idx        <= '0;
        cnt        <= '0;
        fill       <= '0;
        overflow   <= 1'b0;
        slot_valid <= '0;
        slot_idx   <= '0;
        slot_x     <= '0;
        slot_row   <= '0;
      end else if (state == SCAN) begin
        if (idx != IDX_MAX) idx <= idx + 1'b1;
        cnt <= cnt + 1'b1;
        if (cnt != '0 && hit) begin
          if (fill == FILL_MAX) begin
            overflow <= 1'b1;
          end else begin
            // slots fill in order, so the fill count is the lowest free slot
            for (int n = 0; n < MAX_PER_LINE; n++) begin
              if (fill == FILL_W'(n)) begin
                slot_valid[n] <= 1'b1;
                slot_idx[n]   <= eval_idx;
                slot_x[n]     <= s_x;
                slot_row[n]   <= diff[7:0];
              end
            end
            fill <= fill + 1'b1;
          end
        end
        if (cnt == CNT_LAST) begin
          state <= IDLE;
          done  <= 1'b1;
        end
      end
    end
  end

  assign bus.o_spirit_idx = idx;
  assign bus.o_busy       = (state == SCAN);
  assign bus.o_done       = done;
  assign bus.o_overflow   = overflow;
  assign bus.o_slot_valid = slot_valid;
  assign bus.o_slot_idx   = slot_idx;
  assign bus.o_slot_x     = slot_x;
  assign bus.o_slot_row   = slot_row;
endmodule

// File: tb/tb_spirit_line_scheduler.sv
module tb_spirit_line_scheduler;
  localparam int IDX_W = 5;
  localparam int MAXS  = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   failed = 0;

  always #5 clk = ~clk;

  spirit_line_scheduler_if #(.IDX_W(IDX_W), .MAX_PER_LINE(MAXS)) bus ();

  spirit_line_scheduler #(.SPIRIT_COUNT(32), .IDX_W(IDX_W), .MAX_PER_LINE(MAXS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // sprite memory: 1-cycle read latency
  logic [63:0] mem [32];
  always @(posedge clk) bus.i_spirit_struct <= mem[bus.o_spirit_idx];

  function automatic logic [63:0] mk(input logic [15:0] x, input logic [15:0] y,
                                     input logic [7:0] h, input logic en);
    return {23'h5A5A5, en, h, y, x};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // background: disabled sprites that would otherwise cover lines 0..254
  task automatic clear_mem();
    for (int i = 0; i < 32; i++) mem[i] = mk(16'(i * 3), 16'd0, 8'd255, 1'b0);
  endtask

  function automatic logic [4:0] sidx(input int n);
    return bus.o_slot_idx[n*IDX_W +: IDX_W];
  endfunction
  function automatic logic [15:0] sx(input int n);
    return bus.o_slot_x[n*16 +: 16];
  endfunction
  function automatic logic [7:0] srow(input int n);
    return bus.o_slot_row[n*8 +: 8];
  endfunction

  // leaves us at the negedge of cycle T+1
  task automatic pulse(input logic [15:0] y);
    @(negedge clk);
    bus.i_line_y     = y;
    bus.i_line_start = 1'b1;
    @(negedge clk);
    bus.i_line_start = 1'b0;
  endtask

  // from the negedge of T+1, returns c such that o_done is seen at T+c
  task automatic wait_done(output int lat);
    lat = 1;
    while (!bus.o_done && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_line(input logic [15:0] y, output int lat);
    pulse(y);
    wait_done(lat);
  endtask

  typedef struct {
    int          s;
    logic [15:0] x, y;
    logic [7:0]  h;
    logic        en;
    logic [15:0] line;
    logic [7:0]  exp_valid;
    logic [4:0]  exp_idx;
    logic [15:0] exp_x;
    logic [7:0]  exp_row;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int lat, lat2, bad, done_c, ndone;

    vecs[0]  = '{3,  16'd100,  16'd10,     8'd16,  1'b1, 16'd12,     8'h01, 5'd3,  16'd100,  8'd2};
    vecs[1]  = '{3,  16'd100,  16'd10,     8'd16,  1'b1, 16'd9,      8'h00, 5'd0,  16'd0,    8'd0};
    vecs[2]  = '{3,  16'd100,  16'd10,     8'd16,  1'b1, 16'd26,     8'h00, 5'd0,  16'd0,    8'd0};
    vecs[3]  = '{3,  16'd100,  16'd10,     8'd16,  1'b1, 16'd10,     8'h01, 5'd3,  16'd100,  8'd0};
    vecs[4]  = '{3,  16'd100,  16'd10,     8'd16,  1'b1, 16'd25,     8'h01, 5'd3,  16'd100,  8'd15};
    vecs[5]  = '{3,  16'd100,  16'd12,     8'd0,   1'b1, 16'd12,     8'h00, 5'd0,  16'd0,    8'd0};
    vecs[6]  = '{3,  16'd100,  16'd10,     8'd16,  1'b0, 16'd12,     8'h00, 5'd0,  16'd0,    8'd0};
    vecs[7]  = '{5,  16'd77,   16'hFFF0,   8'd32,  1'b1, 16'h0005,   8'h00, 5'd0,  16'd0,    8'd0};
    vecs[8]  = '{5,  16'd77,   16'hFFF0,   8'd32,  1'b1, 16'hFFFF,   8'h01, 5'd5,  16'd77,   8'd15};
    vecs[9]  = '{31, 16'd7,    16'd0,      8'd1,   1'b1, 16'd0,      8'h01, 5'd31, 16'd7,    8'd0};
    vecs[10] = '{0,  16'hFFFF, 16'd200,    8'd255, 1'b1, 16'd454,    8'h01, 5'd0,  16'hFFFF, 8'd254};

    clear_mem();
    rst_n            = 1'b0;
    bus.i_line_start = 1'b0;
    bus.i_line_y     = '0;
    repeat (3) @(negedge clk);
    chk("rst_idx", bus.o_spirit_idx, 0);
    chk("rst_busy", bus.o_busy, 0);
    chk("rst_done", bus.o_done, 0);
    chk("rst_ovf", bus.o_overflow, 0);
    chk("rst_slots", {bus.o_slot_valid, bus.o_slot_idx, bus.o_slot_x}, 0);
    chk("rst_rows", bus.o_slot_row, 0);
    rst_n = 1'b1;

    // single-sprite vectors
    for (int v = 0; v < 11; v++) begin
      clear_mem();
      mem[vecs[v].s] = mk(vecs[v].x, vecs[v].y, vecs[v].h, vecs[v].en);
      run_line(vecs[v].line, lat);
      chk($sformatf("v%0d_latency", v), lat, 34);
      chk($sformatf("v%0d_busy", v), bus.o_busy, 0);
      chk($sformatf("v%0d_valid", v), bus.o_slot_valid, vecs[v].exp_valid);
      chk($sformatf("v%0d_ovf", v), bus.o_overflow, 0);
      if (vecs[v].exp_valid != 0) begin
        chk($sformatf("v%0d_idx", v), sidx(0), vecs[v].exp_idx);
        chk($sformatf("v%0d_x", v), sx(0), vecs[v].exp_x);
        chk($sformatf("v%0d_row", v), srow(0), vecs[v].exp_row);
      end
      @(negedge clk);
      chk($sformatf("v%0d_done_1cyc", v), bus.o_done, 0);
    end

    // overflow: sprites 0..9 all cover line 50, row = index
    clear_mem();
    for (int i = 0; i < 10; i++) mem[i] = mk(16'(i * 10), 16'(50 - i), 8'd20, 1'b1);
    run_line(16'd50, lat);
    chk("ovf_latency", lat, 34);
    chk("ovf_valid", bus.o_slot_valid, 8'hFF);
    chk("ovf_flag", bus.o_overflow, 1);
    for (int n = 0; n < MAXS; n++) begin
      chk($sformatf("ovf_s%0d_idx", n), sidx(n), n);
      chk($sformatf("ovf_s%0d_x", n), sx(n), n * 10);
      chk($sformatf("ovf_s%0d_row", n), srow(n), n);
    end
    repeat (3) @(negedge clk);
    chk("ovf_sticky", bus.o_overflow, 1);
    chk("ovf_hold_valid", bus.o_slot_valid, 8'hFF);
    chk("ovf_hold_row", srow(7), 7);

    // next line with two hits; also walk the index sequence
    clear_mem();
    mem[4] = mk(16'd40, 16'd45, 8'd10, 1'b1);
    mem[7] = mk(16'd70, 16'd50, 8'd1, 1'b1);
    pulse(16'd50);
    chk("t1_busy", bus.o_busy, 1);
    chk("t1_ovf_clr", bus.o_overflow, 0);
    chk("t1_valid_clr", bus.o_slot_valid, 0);
    bad = 0;
    done_c = 0;
    for (int c = 1; c <= 36; c++) begin
      if (c <= 34 && bus.o_spirit_idx !== 5'((c - 1 > 31) ? 31 : c - 1)) bad++;
      if (bus.o_done && done_c == 0) done_c = c;
      if (c < 36) @(negedge clk);
    end
    chk("idx_seq_errors", bad, 0);
    chk("two_done_at", done_c, 34);
    chk("two_valid", bus.o_slot_valid, 8'h03);
    chk("two_ovf", bus.o_overflow, 0);
    chk("two_s0", {sidx(0), sx(0), srow(0)}, {5'd4, 16'd40, 8'd5});
    chk("two_s1", {sidx(1), sx(1), srow(1)}, {5'd7, 16'd70, 8'd0});

    // abort: restart at T+10 for a different line
    clear_mem();
    mem[3]  = mk(16'd100, 16'd10, 8'd16, 1'b1);
    mem[20] = mk(16'd200, 16'd100, 8'd4, 1'b1);
    pulse(16'd12);
    ndone = 0;
    done_c = 0;
    for (int c = 1; c <= 60; c++) begin
      if (bus.o_done) begin ndone++; done_c = c; end
      if (c == 10) begin
        chk("abort_pre_s0", sidx(0), 3);
        bus.i_line_y     = 16'd101;
        bus.i_line_start = 1'b1;
      end
      if (c == 11) bus.i_line_start = 1'b0;
      @(negedge clk);
    end
    chk("abort_ndone", ndone, 1);
    chk("abort_done_at", done_c, 44);
    chk("abort_valid", bus.o_slot_valid, 8'h01);
    chk("abort_s0", {sidx(0), sx(0), srow(0)}, {5'd20, 16'd200, 8'd1});

    // reset mid-scan
    pulse(16'd12);
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", bus.o_busy, 0);
    chk("mrst_idx", bus.o_spirit_idx, 0);
    chk("mrst_valid", bus.o_slot_valid, 0);
    chk("mrst_slots", {bus.o_slot_idx, bus.o_slot_x, bus.o_slot_row}, 0);
    chk("mrst_flags", {bus.o_done, bus.o_overflow}, 0);
    ndone = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (bus.o_done) ndone++;
    end
    chk("mrst_no_done", ndone, 0);
    rst_n = 1'b1;
    run_line(16'd12, lat);
    chk("mrst_latency", lat, 34);
    chk("mrst_s0", {bus.o_slot_valid, sidx(0), srow(0)}, {8'h01, 5'd3, 8'd2});

    // line-start in the same cycle as done
    pulse(16'd12);
    wait_done(lat);
    chk("same_first_latency", lat, 34);
    bus.i_line_y     = 16'd101;
    bus.i_line_start = 1'b1;
    @(negedge clk);
    bus.i_line_start = 1'b0;
    chk("same_restart_busy", bus.o_busy, 1);
    chk("same_restart_clr", bus.o_slot_valid, 0);
    wait_done(lat2);
    chk("same_second_latency", lat2, 34);
    chk("same_s0", {bus.o_slot_valid, sidx(0), srow(0)}, {8'h01, 5'd20, 8'd1});

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
